halli_judge_multi: RTL



---
 rtl/halli_pkg.sv | 20 ++
 rtl/halli_judge_multi_fruit_sum_judge.sv | 35 +++
 rtl/halli_judge_multi.sv | 115 +++++++++++
 3 files changed

// File: rtl/halli_pkg.sv
// Shared constants, FSM state type and sum-width helper for the multi-card bell judge.
package halli_pkg;

   localparam logic [3:0] BELL_CODE    = 4'b1001;
   localparam logic [3:0] CONFIRM_CODE = 4'b0111;
   localparam int         FRUIT_EMPTY  = 0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      JUDGE  = 2'd2,
      RESULT = 2'd3
   } state_t;

   // Wide enough that NUM_CARDS maximum counts can never overflow.
   function automatic int sum_w(input int count_w, input int num_cards);
      return count_w + $clog2(num_cards);
   endfunction

endpackage

// File: rtl/halli_judge_multi_fruit_sum_judge.sv
// Combinational judge: match=1 when any non-empty fruit's summed count equals TARGET.
module fruit_sum_judge #(
   parameter int NUM_CARDS = 4,
   parameter int FRUIT_W   = 2,
   parameter int COUNT_W   = 3,
   parameter int TARGET    = 5
) (
   input  logic [NUM_CARDS*FRUIT_W-1:0] card_fruit,
   input  logic [NUM_CARDS*COUNT_W-1:0] card_count,
   output logic                         match
);
   import halli_pkg::*;

   localparam int SUM_W      = sum_w(COUNT_W, NUM_CARDS);
   localparam int NUM_FRUITS = 1 << FRUIT_W;

   logic [SUM_W-1:0] sum;

   always_comb begin
      match = 1'b0;
      sum   = '0;
      for (int f = FRUIT_EMPTY + 1; f < NUM_FRUITS; f++) begin
         sum = '0;
         for (int i = 0; i < NUM_CARDS; i++) begin
            if (card_fruit[i*FRUIT_W +: FRUIT_W] == FRUIT_W'(f)) begin
               sum = sum + SUM_W'(card_count[i*COUNT_W +: COUNT_W]);
            end
         end
         if (sum == SUM_W'(TARGET)) begin
            match = 1'b1;
         end
      end
   end

endmodule

// File: rtl/halli_judge_multi.sv
// Keypad bell-sequence watcher: snapshots cards on confirm, pulses right/wrong, keeps a saturating score.
module halli_judge_multi #(
   parameter int                NUM_CARDS    = 4,
   parameter int                FRUIT_W      = 2,
   parameter int                COUNT_W      = 3,
   parameter int                TARGET       = 5,
   parameter int                KEY_W        = 4,
   parameter logic [KEY_W-1:0]  BELL_CODE    = halli_pkg::BELL_CODE,
   parameter logic [KEY_W-1:0]  CONFIRM_CODE = halli_pkg::CONFIRM_CODE,
   parameter int                TIMEOUT      = 16,
   parameter int                SCORE_W      = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [KEY_W-1:0]             keypad_in,
   input  logic                         keypad_valid,
   input  logic [NUM_CARDS*FRUIT_W-1:0] card_fruit,
   input  logic [NUM_CARDS*COUNT_W-1:0] card_count,
   output logic                         right,
   output logic                         wrong,
   output logic                         busy,
   output logic [SCORE_W-1:0]           score
);
   import halli_pkg::*;

   localparam int TIMER_W = 8;

   state_t                       state;
   logic                         key_prev;
   logic                         key_event;
   logic [TIMER_W-1:0]           timer;
   logic [NUM_CARDS*FRUIT_W-1:0] snap_fruit;
   logic [NUM_CARDS*COUNT_W-1:0] snap_count;
   logic                         match;

   // Rising edge of keypad_valid only, so a held key yields exactly one event.
   assign key_event = keypad_valid & ~key_prev;

   fruit_sum_judge #(
      .NUM_CARDS (NUM_CARDS),
      .FRUIT_W   (FRUIT_W),
      .COUNT_W   (COUNT_W),
      .TARGET    (TARGET)
   ) u_judge (
      .card_fruit (snap_fruit),
      .card_count (snap_count),
      .match      (match)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         right      <= 1'b0;
         wrong      <= 1'b0;
         busy       <= 1'b0;
         score      <= '0;
         snap_fruit <= '0;
         snap_count <= '0;
         timer      <= '0;
         key_prev   <= 1'b0;
      end else begin
         key_prev <= keypad_valid;
         right    <= 1'b0;
         wrong    <= 1'b0;
         case (state)
            IDLE: begin
               if (key_event && keypad_in == BELL_CODE) begin
                  state <= ARMED;
                  timer <= '0;
                  busy  <= 1'b1;
               end
            end
            ARMED: begin
               // A key event wins over timer expiry in the same cycle.
               if (key_event) begin
                  if (keypad_in == CONFIRM_CODE) begin
                     state      <= JUDGE;
                     snap_fruit <= card_fruit;
                     snap_count <= card_count;
                  end else if (keypad_in == BELL_CODE) begin
                     timer <= '0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            JUDGE: begin
               state <= RESULT;
               busy  <= 1'b0;
               right <= match;
               wrong <= ~match;
            end
            RESULT: begin
               state <= IDLE;
               if (right && score != {SCORE_W{1'b1}}) begin
                  score <= score + 1'b1;
               end else if (wrong && score != '0) begin
                  score <= score - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
